game_state_ctrl: RTL and testbench

Game-level sequencer between the collision/win logic and the VGA colour output stage. It holds the game in idle until the player first presses a direction, then runs play. On a death it freezes movement, flashes the screen for a fixed number of frames and spends a life. It ends in a game-over or win screen until restart, and drives the respawn, freeze and overlay controls that the sprite modules and the pixel colour mux consume.

---
 rtl/game_state_ctrl.sv | 145 ++++++++++++++
 tb/tb_game_state_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/game_state_ctrl.sv
// Game-level sequencer: idle/play/dying/over/win, driving freeze, respawn and colour overlay.
// Define GAME_STATE_CTRL_LIVES_EN for the multi-life counter; otherwise the first death ends the game.
module game_state_ctrl #(
  parameter int unsigned LIVES        = 3,
  parameter int unsigned DEATH_FRAMES = 60,
  parameter int unsigned FLASH_LOG2   = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       restart,
  input  logic       death,
  input  logic       game_over_in,
  input  logic       player_wins,
  input  logic       vsync,
  output logic [2:0] state,
  output logic [1:0] lives,
  output logic       freeze,
  output logic       respawn,
  output logic [1:0] overlay
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PLAY  = 3'd1,
    S_DYING = 3'd2,
    S_OVER  = 3'd3,
    S_WIN   = 3'd4
  } state_e;

  localparam logic [7:0] LAST_FRAME = 8'(DEATH_FRAMES - 1);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       vsync_q;
  logic       tick;
  logic       freeze_q;
  logic       respawn_q, respawn_d;
  logic [1:0] overlay_q, overlay_d;

`ifdef GAME_STATE_CTRL_LIVES_EN
  localparam logic [1:0] LIVES_INIT = 2'(LIVES);
  logic [1:0] lives_q, lives_d;
  assign lives = lives_q;
`else
  logic [1:0] unused_lives;
  assign unused_lives = 2'(LIVES);
  assign lives        = 2'd1;
`endif

  // Falling edge of vsync marks one frame.
  assign tick = vsync_q & ~vsync;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    respawn_d = 1'b0;
`ifdef GAME_STATE_CTRL_LIVES_EN
    lives_d   = lives_q;
`endif
    if (restart) begin
      state_d   = S_IDLE;
      cnt_d     = '0;
      respawn_d = 1'b1;
`ifdef GAME_STATE_CTRL_LIVES_EN
      lives_d   = LIVES_INIT;
`endif
    end else begin
      case (state_q)
        S_IDLE:  if (start && !death) state_d = S_PLAY;
        S_PLAY: begin
          if (death || game_over_in) begin
            state_d = S_DYING;
            cnt_d   = '0;
          end else if (player_wins) begin
            state_d = S_WIN;
          end
        end
        S_DYING: begin
          if (tick) begin
            if (cnt_q == LAST_FRAME) begin
              cnt_d = '0;
`ifdef GAME_STATE_CTRL_LIVES_EN
              if (lives_q != 2'd0) lives_d = lives_q - 2'd1;
              if (lives_q <= 2'd1) begin
                state_d = S_OVER;
              end else begin
                state_d   = S_IDLE;
                respawn_d = 1'b1;
              end
`else
              state_d = S_OVER;
`endif
            end else begin
              cnt_d = cnt_q + 8'd1;
            end
          end
        end
        S_OVER, S_WIN: ;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Overlay is derived from the next state so it registers alongside it.
  always_comb begin
    overlay_d = 2'b00;
    case (state_d)
      S_DYING: overlay_d = cnt_d[FLASH_LOG2] ? 2'b00 : 2'b01;
      S_OVER:  overlay_d = 2'b01;
      S_WIN:   overlay_d = 2'b10;
      default: overlay_d = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      vsync_q   <= 1'b1;
      freeze_q  <= 1'b1;
      respawn_q <= 1'b0;
      overlay_q <= 2'b00;
`ifdef GAME_STATE_CTRL_LIVES_EN
      lives_q   <= LIVES_INIT;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      vsync_q   <= vsync;
      freeze_q  <= (state_d != S_PLAY);
      respawn_q <= respawn_d;
      overlay_q <= overlay_d;
`ifdef GAME_STATE_CTRL_LIVES_EN
      lives_q   <= lives_d;
`endif
    end
  end

  assign state   = state_q;
  assign freeze  = freeze_q;
  assign respawn = respawn_q;
  assign overlay = overlay_q;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Directed literal checks plus randomized stimulus against a frame-level game model.
module tb_game_state_ctrl;
  localparam int DF = 4;
  localparam int FL = 0;
  localparam int LV = 3;
`ifdef GAME_STATE_CTRL_LIVES_EN
  localparam int LV0 = LV;
`else
  localparam int LV0 = 1;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0, start = 1'b0, restart = 1'b0, death = 1'b0;
  logic game_over_in = 1'b0, player_wins = 1'b0, vsync = 1'b1;
  logic [2:0] state;
  logic [1:0] lives;
  logic       freeze, respawn;
  logic [1:0] overlay;

  int total = 0;
  int bad   = 0;

  game_state_ctrl #(.LIVES(LV), .DEATH_FRAMES(DF), .FLASH_LOG2(FL)) dut (
    .clk(clk), .reset(reset), .start(start), .restart(restart), .death(death),
    .game_over_in(game_over_in), .player_wins(player_wins), .vsync(vsync),
    .state(state), .lives(lives), .freeze(freeze), .respawn(respawn), .overlay(overlay)
  );

  always #5 clk = ~clk;

  // Reference model: 0 idle, 1 play, 2 dying, 3 over, 4 win.
  int m_st = 0, m_lv = LV0, m_ticks = 0;
  bit m_resp = 0, m_vs = 1, m_valid = 0;

  function automatic int m_overlay();
    if (m_st == 2) return (((m_ticks >> FL) % 2) == 0) ? 1 : 0;
    if (m_st == 3) return 1;
    if (m_st == 4) return 2;
    return 0;
  endfunction

  always @(posedge clk) begin
    bit tk;
    tk = m_vs && !vsync;
    m_vs = vsync;
    m_resp = 0;
    if (!reset) begin
      m_st = 0; m_lv = LV0; m_ticks = 0; m_vs = 1; m_valid = 1;
    end else if (restart) begin
      m_st = 0; m_lv = LV0; m_ticks = 0; m_resp = 1;
    end else if (m_st == 0) begin
      if (start && !death) m_st = 1;
    end else if (m_st == 1) begin
      if (death || game_over_in) begin m_st = 2; m_ticks = 0; end
      else if (player_wins) m_st = 4;
    end else if (m_st == 2 && tk) begin
      m_ticks++;
      if (m_ticks == DF) begin
`ifdef GAME_STATE_CTRL_LIVES_EN
        if (m_lv <= 1) m_st = 3;
        else begin m_st = 0; m_resp = 1; end
        if (m_lv > 0) m_lv--;
`else
        m_st = 3;
`endif
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      total++;
      if (state !== 3'(m_st) || lives !== 2'(m_lv) || freeze !== (m_st != 1) ||
          respawn !== m_resp || overlay !== 2'(m_overlay())) begin
        bad++;
        $display("FAIL model t=%0t got st=%0d lv=%0d fr=%0d rs=%0d ov=%0d want st=%0d lv=%0d fr=%0d rs=%0d ov=%0d",
                 $time, state, lives, freeze, respawn, overlay,
                 m_st, m_lv, (m_st != 1), m_resp, m_overlay());
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic tick_pulse();
    vsync = 1'b1; step();
    vsync = 1'b0; step();
    vsync = 1'b1;
  endtask

  task automatic chk(input string nm, input int st, input int lv, input int fr, input int rs, input int ov);
    total++;
    if (state !== 3'(st) || lives !== 2'(lv) || freeze !== 1'(fr) || respawn !== 1'(rs) || overlay !== 2'(ov)) begin
      bad++;
      $display("FAIL %s got st=%0d lv=%0d fr=%0d rs=%0d ov=%0d want st=%0d lv=%0d fr=%0d rs=%0d ov=%0d",
               nm, state, lives, freeze, respawn, overlay, st, lv, fr, rs, ov);
    end
  endtask

  task automatic pulse_restart();
    restart = 1'b1; step(); restart = 1'b0;
  endtask

  initial begin
    step(); step();
    reset = 1'b1;
    chk("reset", 0, LV0, 1, 0, 0);
    start = 1'b1; step(); start = 1'b0;
    chk("start", 1, LV0, 0, 0, 0);
    death = 1'b1; step(); death = 1'b0;
    chk("dying_entry", 2, LV0, 1, 0, 1);
    tick_pulse(); chk("tick1", 2, LV0, 1, 0, 0);
    tick_pulse(); chk("tick2", 2, LV0, 1, 0, 1);
    tick_pulse(); chk("tick3", 2, LV0, 1, 0, 0);
    tick_pulse();
`ifdef GAME_STATE_CTRL_LIVES_EN
    chk("respawn_exit", 0, 2, 1, 1, 0);
    step(); chk("respawn_once", 0, 2, 1, 0, 0);
`else
    chk("single_life_over", 3, 1, 1, 0, 1);
    step(); chk("over_hold", 3, 1, 1, 0, 1);
`endif
    pulse_restart(); chk("restart", 0, LV0, 1, 1, 0);
    start = 1'b1; step(); start = 1'b0;
    death = 1'b1; player_wins = 1'b1; step(); death = 1'b0; player_wins = 1'b0;
    chk("death_beats_win", 2, LV0, 1, 0, 1);
    pulse_restart();
    start = 1'b1; step(); start = 1'b0;
    death = 1'b1; player_wins = 1'b1; restart = 1'b1; step();
    death = 1'b0; player_wins = 1'b0; restart = 1'b0;
    chk("restart_beats_all", 0, LV0, 1, 1, 0);
    start = 1'b1; step(); start = 1'b0;
    player_wins = 1'b1; step(); player_wins = 1'b0;
    chk("win", 4, LV0, 1, 0, 2);
    pulse_restart(); chk("win_restart", 0, LV0, 1, 1, 0);
    step(); chk("win_restart_once", 0, LV0, 1, 0, 0);
`ifdef GAME_STATE_CTRL_LIVES_EN
    for (int k = 0; k < 3; k++) begin
      start = 1'b1; step(); start = 1'b0;
      death = 1'b1; step(); death = 1'b0;
      for (int t = 0; t < DF; t++) tick_pulse();
      if (k < 2) chk("life_lost", 0, 2 - k, 1, 1, 0);
      else       chk("last_life_over", 3, 0, 1, 0, 1);
    end
    pulse_restart();
`endif
    start = 1'b1; step(); start = 1'b0;
    game_over_in = 1'b1; step(); game_over_in = 1'b0;
    tick_pulse();
    reset = 1'b0; step(); reset = 1'b1;
    chk("reset_mid_dying", 0, LV0, 1, 0, 0);

    begin
      int vcnt;
      vcnt = 0;
      for (int c = 0; c < 4000; c++) begin
        start        = ($urandom_range(0, 2) == 0);
        death        = ($urandom_range(0, 7) == 0);
        game_over_in = ($urandom_range(0, 19) == 0);
        player_wins  = ($urandom_range(0, 24) == 0);
        restart      = ($urandom_range(0, 59) == 0);
        reset        = ($urandom_range(0, 299) != 0);
        if (vcnt == 0) begin
          vsync = 1'b0;
          vcnt  = $urandom_range(1, 4);
        end else begin
          vsync = 1'b1;
          vcnt--;
        end
        step();
      end
    end
    reset = 1'b1; start = 1'b0; death = 1'b0; game_over_in = 1'b0;
    player_wins = 1'b0; restart = 1'b0; vsync = 1'b1;
    step(); step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
